pp_uart_fifo_transceiver: RTL and testbench
===========================================

PP_UART_FIFO_TRANSCEIVER -- requirements
Module: pp_uart_fifo_transceiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, TX and RX FIFO entries each; power of two, minimum 2.
REQ-002 SHALL have parameter BAUD_W, default 14, width of baud_div.
REQ-003 SHALL have parameter OVS, default 16, receiver oversampling ticks per bit; even, minimum 4.
REQ-004 SHALL have these ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- soft_rst  in  1  synchronous, active-high; same effect as rst.
- baud_div  in  BAUD_W  tick period minus one.
- data_flag  in  2  00/01/10/11 = 5/6/7/8 data bits.
- stop_flag  in  1  0 = 1 stop bit; 1 = 2 stop bits.
- check_flag  in  2  00 none, 01 odd, 10 even, 11 treated as none.
- tx_data  in  8  byte to send.
- tx_valid  in  1  push request.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  8  head of RX FIFO; unused upper bits zero.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  pop request.
- uart_tx  out  1  serial output; idle high.
- uart_rx  in  1  asynchronous serial input.
- tx_level, rx_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- tx_idle  out  1  TX FIFO empty and TX FSM in IDLE.
- parity_err, frame_err, overrun  out  1  sticky error flags.
- err_clr  in  1  clears all sticky flags.

Function
REQ-005 SHALL pulse a one-cycle tick every baud_div+1 clk cycles; baud_div=0 gives a tick every cycle.
REQ-006 SHALL push tx_data when tx_valid and tx_ready are both high in the same cycle; SHALL ignore tx_valid while full.
REQ-007 SHALL pop the RX FIFO when rx_valid and rx_ready are both high; rx_data is valid combinationally from the FIFO head.
REQ-008 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; each bit lasts OVS ticks.
- PARITY is skipped when parity is none.
- STOP lasts 1 or 2 bits.
- The byte is loaded from the FIFO in IDLE.
- Data is sent LSB first, data_flag bits only.
REQ-009 TX SHALL go STOP->START back-to-back, with no idle bit, when the FIFO is non-empty at the end of STOP.
REQ-010 Parity bit SHALL make the total count of ones (data plus parity) odd for 01 and even for 10.
REQ-011 Receiver SHALL pass uart_rx through a 2-flop synchroniser reset to 1.
REQ-012 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- A falling edge in IDLE enters START.
- At tick OVS/2: line still low goes to DATA; line high is a false start and returns to IDLE with no flag.
REQ-013 RX SHALL sample each subsequent bit at its centre, i.e. every OVS ticks after the start-bit centre.
REQ-014 RX SHALL check only the first stop bit and then return to IDLE.
- Stop bit sampled 0 sets frame_err; the byte is still written.
- Parity mismatch sets parity_err; the byte is still written.
REQ-015 A received byte arriving when the RX FIFO is full SHALL be discarded and SHALL set overrun.
REQ-016 A push and a pop in the same cycle on a full FIFO (RX write) or an empty FIFO (TX read) SHALL follow the pre-cycle state: full blocks the write, empty blocks the read.
REQ-017 Sticky flags SHALL clear on err_clr. A set event in the same cycle as err_clr SHALL win.
REQ-018 Configuration inputs SHALL be sampled at frame start and held for the whole frame; mid-frame changes SHALL take effect on the next frame.
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-020 On rst low (asynchronous), or on soft_rst at a clock edge:
- FIFOs empty; tx_ready=1, rx_valid=0.
- Levels 0, uart_tx=1, tx_idle=1, all flags 0.
- FSMs in IDLE; baud counter 0.
- rx_data=0.
REQ-021 Reset mid-frame SHALL drive uart_tx high immediately and SHALL discard the partial frame.

Structure
REQ-022 A shared package SHALL hold:
- TX/RX state encodings.
- Parity-mode and data-length constants.
REQ-023 One sub-module, pp_uart_sync_fifo (parameters WIDTH and DEPTH), SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-024 Reset, baud_div=0, 8N1, push 0xA5:
- uart_tx low for 16 clk, then 1,0,1,0,0,1,0,1 for 16 clk each, then high.
- tx_idle=1 at 160 clk after the frame starts.
REQ-025 Loopback uart_tx->uart_rx, 7E2, baud_div=3, push 0x00,0x7F,0x55:
- rx_data is 0x00,0x7F,0x55 in order.
- No error flags set.
REQ-026 With rx_ready=0, loop back FIFO_DEPTH+1 bytes:
- rx_level=16, overrun=1.
- Popping returns the first 16 bytes.
REQ-027 Inject an 8O1 frame with a wrong parity bit, then an 8N1 frame with stop=0:
- parity_err=1, then frame_err=1.
- Both bytes are present in the RX FIFO.
- err_clr clears both flags.
REQ-028 Assert rst mid-DATA bit 3:
- uart_tx=1 in the same cycle.
- Levels 0.
- After release, the next pushed byte is sent intact.
REQ-029 Drive a 3-tick low glitch on uart_rx (OVS=16): no byte received, no flag set.

Source files
------------

// File: rtl/pp_uart_fifo_transceiver_pkg.sv
// Shared types and helpers for the FIFO-buffered UART transceiver.
// Holds FSM state encodings, parity/data-length codes and small bit helpers.
package pp_uart_fifo_transceiver_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam logic [1:0] DLEN_5 = 2'b00;
    localparam logic [1:0] DLEN_6 = 2'b01;
    localparam logic [1:0] DLEN_7 = 2'b10;
    localparam logic [1:0] DLEN_8 = 2'b11;

    function automatic logic [3:0] dataBits(input logic [1:0] flag);
        return 4'd5 + {2'b00, flag};
    endfunction

    // Mode 11 is deliberately treated like "none".
    function automatic logic parityOn(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

    function automatic logic [7:0] maskData(input logic [7:0] d, input logic [1:0] flag);
        return d & (8'hFF >> (2'd3 - flag));
    endfunction

    function automatic logic parityBit(input logic [7:0] d, input logic [1:0] mode);
        return (mode == PAR_ODD) ? ~(^d) : (^d);
    endfunction

endpackage

// File: rtl/pp_uart_fifo_transceiver_sync_fifo.sv
// Single-clock FIFO used for both the TX and RX byte queues.
// Full/empty come from the registered level, so a same-cycle push/pop obeys the pre-cycle state.
module pp_uart_sync_fifo
    import pp_uart_fifo_transceiver_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_level;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_level == (AW+1)'(DEPTH));
    assign o_empty  = (r_level == '0);
    assign o_level  = r_level;
    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;
    assign o_rdata  = o_empty ? '0 : r_mem[r_rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else if (i_clr) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_doPush, w_doPop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_wdata;
    end

endmodule

// File: rtl/pp_uart_fifo_transceiver.sv
// UART transceiver with TX/RX FIFOs, shared baud tick, oversampled receiver and sticky errors.
// Frame format (data length, parity, stop bits) is captured per frame at its start.
module pp_uart_fifo_transceiver
    import pp_uart_fifo_transceiver_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int BAUD_W     = 14,
    parameter int OVS        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        soft_rst,
    input  logic [BAUD_W-1:0]           baud_div,
    input  logic [1:0]                  data_flag,
    input  logic                        stop_flag,
    input  logic [1:0]                  check_flag,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic                        uart_tx,
    input  logic                        uart_rx,
    output logic [$clog2(FIFO_DEPTH):0] tx_level,
    output logic [$clog2(FIFO_DEPTH):0] rx_level,
    output logic                        tx_idle,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        overrun,
    input  logic                        err_clr
);

    localparam int TCW = $clog2(OVS);

    logic [BAUD_W-1:0] r_baudCnt;
    logic              w_tick;

    tx_state_t  r_txState, w_txNext;
    logic [TCW-1:0] r_txTick;
    logic [2:0] r_txBit;
    logic [7:0] r_txShift;
    logic [3:0] r_txNBits;
    logic       r_txParOn, r_txParBit, r_txTwoStop;
    logic       w_txPop, w_txLine, w_txBitEnd, w_txFull, w_txEmpty;
    logic [7:0] w_txHead;

    rx_state_t  r_rxState, w_rxNext;
    logic [1:0] r_rxSync;
    logic       r_rxPrev;
    logic [TCW-1:0] r_rxTick;
    logic [2:0] r_rxBit;
    logic [7:0] r_rxShift;
    logic [3:0] r_rxNBits;
    logic [1:0] r_rxParMode;
    logic       w_rxIn, w_rxSample, w_rxPush, w_rxFull, w_rxEmpty;
    logic       w_parEv, w_frameEv, w_ovrEv;

    assign w_tick = (r_baudCnt >= baud_div);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_baudCnt <= '0;
        else if (soft_rst) r_baudCnt <= '0;
        else               r_baudCnt <= w_tick ? '0 : r_baudCnt + 1'b1;
    end

    pp_uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txFifo (
        .clk(clk), .rst(rst), .i_clr(soft_rst),
        .i_push(tx_valid), .i_wdata(tx_data), .i_pop(w_txPop),
        .o_rdata(w_txHead), .o_full(w_txFull), .o_empty(w_txEmpty), .o_level(tx_level)
    );

    pp_uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rxFifo (
        .clk(clk), .rst(rst), .i_clr(soft_rst),
        .i_push(w_rxPush), .i_wdata(r_rxShift), .i_pop(rx_ready),
        .o_rdata(rx_data), .o_full(w_rxFull), .o_empty(w_rxEmpty), .o_level(rx_level)
    );

    assign tx_ready = ~w_txFull;
    assign rx_valid = ~w_rxEmpty;
    assign tx_idle  = w_txEmpty && (r_txState == TX_IDLE);
    assign uart_tx  = w_txLine;

    assign w_txBitEnd = w_tick && (r_txTick == TCW'(OVS-1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_txState <= TX_IDLE;
        else if (soft_rst) r_txState <= TX_IDLE;
        else               r_txState <= w_txNext;
    end

    // Line level is decoded from state so any reset forces the line high at once.
    always_comb begin
        w_txNext = r_txState;
        w_txPop  = 1'b0;
        w_txLine = 1'b1;
        case (r_txState)
            TX_IDLE: begin
                if (!w_txEmpty) begin
                    w_txPop  = 1'b1;
                    w_txNext = TX_START;
                end
            end
            TX_START: begin
                w_txLine = 1'b0;
                if (w_txBitEnd) w_txNext = TX_DATA;
            end
            TX_DATA: begin
                w_txLine = r_txShift[0];
                if (w_txBitEnd && ({1'b0, r_txBit} == r_txNBits - 4'd1))
                    w_txNext = r_txParOn ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                w_txLine = r_txParBit;
                if (w_txBitEnd) w_txNext = TX_STOP;
            end
            TX_STOP: begin
                if (w_txBitEnd && (r_txBit[0] == r_txTwoStop)) begin
                    if (!w_txEmpty) begin
                        w_txPop  = 1'b1;
                        w_txNext = TX_START;
                    end else begin
                        w_txNext = TX_IDLE;
                    end
                end
            end
            default: w_txNext = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_txShift <= '0; r_txNBits <= 4'd8; r_txParOn <= 1'b0;
            r_txParBit <= 1'b0; r_txTwoStop <= 1'b0; r_txTick <= '0; r_txBit <= '0;
        end else if (soft_rst) begin
            r_txShift <= '0; r_txNBits <= 4'd8; r_txParOn <= 1'b0;
            r_txParBit <= 1'b0; r_txTwoStop <= 1'b0; r_txTick <= '0; r_txBit <= '0;
        end else if (w_txPop) begin
            r_txShift   <= maskData(w_txHead, data_flag);
            r_txNBits   <= dataBits(data_flag);
            r_txParOn   <= parityOn(check_flag);
            r_txParBit  <= parityBit(maskData(w_txHead, data_flag), check_flag);
            r_txTwoStop <= stop_flag;
            r_txTick    <= '0;
            r_txBit     <= '0;
        end else if (r_txState == TX_IDLE) begin
            r_txTick <= '0;
            r_txBit  <= '0;
        end else if (w_txBitEnd) begin
            r_txTick <= '0;
            if (r_txState == TX_DATA) r_txShift <= r_txShift >> 1;
            r_txBit <= (w_txNext == r_txState) ? r_txBit + 3'd1 : 3'd0;
        end else if (w_tick) begin
            r_txTick <= r_txTick + 1'b1;
        end
    end

    assign w_rxIn     = r_rxSync[1];
    assign w_rxSample = w_tick && (r_rxTick == ((r_rxState == RX_START) ? TCW'(OVS/2-1) : TCW'(OVS-1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rxSync <= 2'b11; r_rxPrev <= 1'b1; r_rxState <= RX_IDLE;
        end else if (soft_rst) begin
            r_rxSync <= 2'b11; r_rxPrev <= 1'b1; r_rxState <= RX_IDLE;
        end else begin
            r_rxSync  <= {r_rxSync[0], uart_rx};
            r_rxPrev  <= w_rxIn;
            r_rxState <= w_rxNext;
        end
    end

    // A start bit still high at its centre is treated as noise and dropped silently.
    always_comb begin
        w_rxNext = r_rxState;
        w_rxPush = 1'b0;
        case (r_rxState)
            RX_IDLE:   if (r_rxPrev && !w_rxIn) w_rxNext = RX_START;
            RX_START:  if (w_rxSample) w_rxNext = w_rxIn ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (w_rxSample && ({1'b0, r_rxBit} == r_rxNBits - 4'd1))
                    w_rxNext = parityOn(r_rxParMode) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (w_rxSample) w_rxNext = RX_STOP;
            RX_STOP: begin
                if (w_rxSample) begin
                    w_rxNext = RX_IDLE;
                    w_rxPush = 1'b1;
                end
            end
            default: w_rxNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rxShift <= '0; r_rxNBits <= 4'd8; r_rxParMode <= PAR_NONE; r_rxTick <= '0; r_rxBit <= '0;
        end else if (soft_rst) begin
            r_rxShift <= '0; r_rxNBits <= 4'd8; r_rxParMode <= PAR_NONE; r_rxTick <= '0; r_rxBit <= '0;
        end else if (r_rxState == RX_IDLE) begin
            r_rxTick <= '0;
            r_rxBit  <= '0;
            if (w_rxNext == RX_START) begin
                r_rxShift   <= '0;
                r_rxNBits   <= dataBits(data_flag);
                r_rxParMode <= check_flag;
            end
        end else if (w_rxSample) begin
            r_rxTick <= '0;
            if (r_rxState == RX_DATA) r_rxShift[r_rxBit] <= w_rxIn;
            r_rxBit <= (w_rxNext == r_rxState) ? r_rxBit + 3'd1 : 3'd0;
        end else if (w_tick) begin
            r_rxTick <= r_rxTick + 1'b1;
        end
    end

    assign w_parEv   = (r_rxState == RX_PARITY) && w_rxSample && (w_rxIn != parityBit(r_rxShift, r_rxParMode));
    assign w_frameEv = (r_rxState == RX_STOP) && w_rxSample && !w_rxIn;
    assign w_ovrEv   = w_rxPush && w_rxFull;

    // A new error event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err <= 1'b0; frame_err <= 1'b0; overrun <= 1'b0;
        end else if (soft_rst) begin
            parity_err <= 1'b0; frame_err <= 1'b0; overrun <= 1'b0;
        end else begin
            parity_err <= w_parEv   | (parity_err & ~err_clr);
            frame_err  <= w_frameEv | (frame_err & ~err_clr);
            overrun    <= w_ovrEv   | (overrun & ~err_clr);
        end
    end

endmodule

// File: tb/tb_pp_uart_fifo_transceiver.sv
// Scoreboard bench for pp_uart_fifo_transceiver: expected RX bytes are queued by stimulus
// and a monitor compares them whenever the DUT hands a byte out.
module tb_pp_uart_fifo_transceiver;

    logic        clk = 1'b0;
    logic        rst, softRst, stopFlag, txValid, txReady, rxValid, rxReady;
    logic [13:0] baudDiv;
    logic [1:0]  dataFlag, checkFlag;
    logic [7:0]  txData, rxData;
    logic        uartTx, uartRx, txIdle, parityErr, frameErr, overrun, errClr;
    logic [4:0]  txLevel, rxLevel;
    logic        loopEn, rxDrive;
    logic [9:0]  frameA5 = 10'b1101001010;

    int          nCompared = 0;
    int          nMismatched = 0;
    logic [7:0]  expQ[$];

    always #5 clk = ~clk;

    assign uartRx = loopEn ? uartTx : rxDrive;

    pp_uart_fifo_transceiver dut (
        .clk(clk), .rst(rst), .soft_rst(softRst), .baud_div(baudDiv),
        .data_flag(dataFlag), .stop_flag(stopFlag), .check_flag(checkFlag),
        .tx_data(txData), .tx_valid(txValid), .tx_ready(txReady),
        .rx_data(rxData), .rx_valid(rxValid), .rx_ready(rxReady),
        .uart_tx(uartTx), .uart_rx(uartRx), .tx_level(txLevel), .rx_level(rxLevel),
        .tx_idle(txIdle), .parity_err(parityErr), .frame_err(frameErr),
        .overrun(overrun), .err_clr(errClr)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every byte handed out (valid && ready) is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst && !softRst && rxValid && rxReady) begin
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL rx_unexpected: got 0x%0h, expected no byte", rxData);
            end else begin
                checkOutput("rx_data", {24'h0, rxData}, {24'h0, expQ.pop_front()});
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        for (int i = 0; i < 5000 && !txReady; i++) @(negedge clk);
        if (!txReady) begin
            checkOutput("tx_push_timeout", 32'(txReady), 32'd1);
        end else begin
            txData  = b;
            txValid = 1'b1;
            @(negedge clk);
            txValid = 1'b0;
        end
    endtask

    task automatic waitFrameStart(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (uartTx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("frame_start_seen", 32'(ok), 32'd1);
    endtask

    task automatic waitTxIdle(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (txIdle === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput(name, 32'(ok), 32'd1);
        repeat (40) @(negedge clk);
    endtask

    task automatic waitRxDrained(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (expQ.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput(name, 32'(ok), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic sendSerial(input logic [7:0] d, input int nbits, input bit hasPar,
                              input bit parBit, input bit stopBit);
        int bc = 16 * (int'(baudDiv) + 1);
        rxDrive = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rxDrive = d[i];
            repeat (bc) @(negedge clk);
        end
        if (hasPar) begin
            rxDrive = parBit;
            repeat (bc) @(negedge clk);
        end
        rxDrive = stopBit;
        repeat (bc) @(negedge clk);
        rxDrive = 1'b1;
        repeat (2 * bc) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        rst = 1'b0; softRst = 1'b0; baudDiv = '0; dataFlag = 2'b11; stopFlag = 1'b0;
        checkFlag = 2'b00; txData = '0; txValid = 1'b0; rxReady = 1'b0; errClr = 1'b0;
        loopEn = 1'b0; rxDrive = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_tx_ready", 32'(txReady), 32'd1);
        checkOutput("rst_rx_valid", 32'(rxValid), 32'd0);
        checkOutput("rst_tx_level", 32'(txLevel), 32'd0);
        checkOutput("rst_rx_level", 32'(rxLevel), 32'd0);
        checkOutput("rst_uart_tx", 32'(uartTx), 32'd1);
        checkOutput("rst_tx_idle", 32'(txIdle), 32'd1);
        checkOutput("rst_flags", 32'({parityErr, frameErr, overrun}), 32'd0);
        checkOutput("rst_rx_data", 32'(rxData), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 0xA5 at one tick per clock: exact bit edges, idle at +160
        loopEn = 1'b1; rxReady = 1'b1;
        expQ.push_back(8'hA5);
        applyStimulus(8'hA5);
        waitFrameStart(ok);
        if (ok) begin
            checkOutput("a5_k0", 32'(uartTx), 32'(frameA5[0]));
            for (int k = 1; k <= 160; k++) begin
                @(negedge clk);
                if (k < 160 && (k % 16 == 0 || k % 16 == 15))
                    checkOutput($sformatf("a5_k%0d", k), 32'(uartTx), 32'(frameA5[k/16]));
                if (k == 159) checkOutput("a5_idle_k159", 32'(txIdle), 32'd0);
                if (k == 160) begin
                    checkOutput("a5_idle_k160", 32'(txIdle), 32'd1);
                    checkOutput("a5_line_k160", 32'(uartTx), 32'd1);
                end
            end
        end
        waitRxDrained("a5_rx_drained", 2000);

        // 7E2 loopback at baud_div=3
        dataFlag = 2'b10; checkFlag = 2'b10; stopFlag = 1'b1; baudDiv = 14'd3;
        expQ.push_back(8'h00); expQ.push_back(8'h7F); expQ.push_back(8'h55);
        applyStimulus(8'h00); applyStimulus(8'h7F); applyStimulus(8'h55);
        waitTxIdle("7e2_tx_idle", 20000);
        waitRxDrained("7e2_rx_drained", 3000);
        checkOutput("7e2_parity_err", 32'(parityErr), 32'd0);
        checkOutput("7e2_frame_err", 32'(frameErr), 32'd0);
        checkOutput("7e2_overrun", 32'(overrun), 32'd0);

        // RX overflow: 17 bytes into a 16-deep RX FIFO with no reader
        dataFlag = 2'b11; checkFlag = 2'b00; stopFlag = 1'b0; baudDiv = '0; rxReady = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) expQ.push_back(8'h20 + 8'(i));
            applyStimulus(8'h20 + 8'(i));
        end
        waitTxIdle("ovf_tx_idle", 20000);
        checkOutput("ovf_rx_level", 32'(rxLevel), 32'd16);
        checkOutput("ovf_overrun", 32'(overrun), 32'd1);
        checkOutput("ovf_head", 32'(rxData), 32'h20);
        rxReady = 1'b1;
        waitRxDrained("ovf_rx_drained", 200);
        checkOutput("ovf_rx_valid_after", 32'(rxValid), 32'd0);
        errClr = 1'b1; @(negedge clk); errClr = 1'b0;
        checkOutput("ovf_overrun_cleared", 32'(overrun), 32'd0);

        // Injected frames: 8O1 with bad parity, then 8N1 with stop bit low
        loopEn = 1'b0; rxReady = 1'b0; checkFlag = 2'b01;
        expQ.push_back(8'h3C);
        sendSerial(8'h3C, 8, 1'b1, 1'b0, 1'b1);
        checkOutput("inj_parity_err", 32'(parityErr), 32'd1);
        checkOutput("inj_frame_err_clear", 32'(frameErr), 32'd0);
        checkFlag = 2'b00;
        expQ.push_back(8'h81);
        sendSerial(8'h81, 8, 1'b0, 1'b0, 1'b0);
        checkOutput("inj_frame_err", 32'(frameErr), 32'd1);
        checkOutput("inj_rx_level", 32'(rxLevel), 32'd2);
        rxReady = 1'b1;
        waitRxDrained("inj_rx_drained", 200);
        rxReady = 1'b0;
        errClr = 1'b1; @(negedge clk); errClr = 1'b0;
        checkOutput("inj_flags_cleared", 32'({parityErr, frameErr}), 32'd0);

        // 3-tick glitch must not start a byte; a real frame afterwards still does
        rxDrive = 1'b0; repeat (3) @(negedge clk); rxDrive = 1'b1;
        repeat (200) @(negedge clk);
        checkOutput("glitch_rx_level", 32'(rxLevel), 32'd0);
        checkOutput("glitch_flags", 32'({parityErr, frameErr, overrun}), 32'd0);
        rxReady = 1'b1;
        expQ.push_back(8'h5A);
        sendSerial(8'h5A, 8, 1'b0, 1'b0, 1'b1);
        waitRxDrained("glitch_next_byte", 200);

        // Async reset in the centre of data bit 3
        rxReady = 1'b0; txData = 8'h00;
        applyStimulus(8'h00);
        waitFrameStart(ok);
        if (ok) begin
            for (int k = 1; k <= 72; k++) begin
                @(negedge clk);
                if (k == 20) txValid = 1'b1;
                else if (k == 22) txValid = 1'b0;
            end
            checkOutput("mid_tx_low", 32'(uartTx), 32'd0);
            checkOutput("mid_tx_level", 32'(txLevel), 32'd2);
            rst = 1'b0;
            #1;
            checkOutput("mid_rst_uart_tx", 32'(uartTx), 32'd1);
            checkOutput("mid_rst_tx_level", 32'(txLevel), 32'd0);
            checkOutput("mid_rst_tx_idle", 32'(txIdle), 32'd1);
            checkOutput("mid_rst_rx_level", 32'(rxLevel), 32'd0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        loopEn = 1'b1; rxReady = 1'b1;
        expQ.push_back(8'hC3);
        applyStimulus(8'hC3);
        waitTxIdle("post_rst_tx_idle", 5000);
        waitRxDrained("post_rst_rx", 500);

        // Synchronous soft reset mid-frame
        loopEn = 1'b0; rxReady = 1'b0;
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        waitFrameStart(ok);
        repeat (30) @(negedge clk);
        checkOutput("soft_pre_level", 32'(txLevel), 32'd1);
        softRst = 1'b1; @(negedge clk); softRst = 1'b0;
        checkOutput("soft_uart_tx", 32'(uartTx), 32'd1);
        checkOutput("soft_tx_level", 32'(txLevel), 32'd0);
        checkOutput("soft_tx_idle", 32'(txIdle), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
